// File: rtl/rr_sched_pkg.sv
// Shared types and constants for the round-robin grant scheduler.
//   state_e : scheduler phase (IDLE / BUSY / GAP)
//   NUM_REQ : number of requesters
//   ID_W    : width of a requester index
package rr_sched_pkg;

   localparam int NUM_REQ = 8;
   localparam int ID_W    = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } state_e;

endpackage

// File: rtl/rr_grant_sched8_if.sv
// Request/grant bus between requesters and the scheduler.
//   req_i         : request lines, bit i = requester i
//   release_i     : owner gives up the resource
//   grant_o       : one-hot grant, zero when no owner
//   grant_valid_o : high when grant_o is non-zero
//   grant_id_o    : index of current or last owner
//   timeout_o     : one-cycle pulse on a forced release
// slave = scheduler side, master = requester side.
interface rr_grant_sched8_if;
   import rr_sched_pkg::*;

   logic [NUM_REQ-1:0] req_i;
   logic               release_i;
   logic [NUM_REQ-1:0] grant_o;
   logic               grant_valid_o;
   logic [ID_W-1:0]    grant_id_o;
   logic               timeout_o;

   modport slave (
      input  req_i, release_i,
      output grant_o, grant_valid_o, grant_id_o, timeout_o
   );

   modport master (
      output req_i, release_i,
      input  grant_o, grant_valid_o, grant_id_o, timeout_o
   );
endinterface

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder.
//   in0..in2 : select, in0 is the MSB
//   enable   : high = decode, low = all outputs high
//   y        : decoded output
module decoder_3to8 (
   input  logic       in0,
   input  logic       in1,
   input  logic       in2,
   input  logic       enable,
   output logic [7:0] y
);
   logic [2:0] sel;

   assign sel = {in0, in1, in2};

   always_comb begin
      y = 8'hFF;
      if (enable) y = 8'h01 << sel;
   end
endmodule

// File: rtl/rr_grant_sched8.sv
// Round-robin scheduler sharing one resource among eight requesters.
// Arbitrates in IDLE/GAP, holds the grant in BUSY until release, dropped
// request or hold timeout, then inserts one dead GAP cycle.
//   clk, reset : clock and synchronous active-high reset
//   bus        : request/grant bus (slave side)
// Parameters:
//   MAX_HOLD : max consecutive grant cycles per owner, 0 = no timeout
//   CNT_W    : hold counter width, 2**CNT_W > MAX_HOLD
module rr_grant_sched8
   import rr_sched_pkg::*;
#(
   parameter int MAX_HOLD = 15,
   parameter int CNT_W    = 4
) (
   input logic            clk,
   input logic            reset,
   rr_grant_sched8_if.slave bus
);

   localparam bit               TO_EN     = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TO_EN ? MAX_HOLD - 1 : 0);

   state_e             state_q,    state_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic [ID_W-1:0]    last_id_q,  last_id_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic               timeout_q,  timeout_d;
   logic               grant_valid;
   logic [NUM_REQ-1:0] dec_y;
   logic [ID_W-1:0]    winner;

   // First set bit searching upward from last+1 with wrap. Scanning the
   // offsets from farthest to nearest lets the nearest hit overwrite; offset
   // NUM_REQ wraps back onto last itself, so the previous owner ranks last.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    last);
      logic [ID_W-1:0] idx;
      rr_pick = last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = last + ID_W'(k);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   assign winner = rr_pick(bus.req_i, last_id_q);

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      last_id_d  = last_id_q;
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
      unique case (state_q)
         IDLE, GAP: begin
            if (|bus.req_i) begin
               state_d    = BUSY;
               grant_id_d = winner;
               last_id_d  = winner;
               cnt_d      = '0;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            // Voluntary or implicit release wins over timeout; timeout only
            // pulses when it is the sole reason for leaving BUSY.
            if (bus.release_i || !bus.req_i[grant_id_q]) begin
               state_d = GAP;
            end else if (TO_EN && cnt_q == HOLD_LAST) begin
               state_d   = GAP;
               timeout_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         last_id_q  <= ID_W'(NUM_REQ - 1);
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         last_id_q  <= last_id_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign grant_valid = (state_q == BUSY);

   decoder_3to8 u_dec (
      .in0    (grant_id_q[2]),
      .in1    (grant_id_q[1]),
      .in2    (grant_id_q[0]),
      .enable (grant_valid),
      .y      (dec_y)
   );

   // Disabled decoder drives all ones, so the mask is required.
   assign bus.grant_o       = grant_valid ? dec_y : '0;
   assign bus.grant_valid_o = grant_valid;
   assign bus.grant_id_o    = grant_id_q;
   assign bus.timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_grant_sched8.sv
module tb_rr_grant_sched8;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   rr_grant_sched8_if bus_a ();
   rr_grant_sched8_if bus_b ();

   rr_grant_sched8 #(.MAX_HOLD(4), .CNT_W(4)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a.slave));
   rr_grant_sched8 #(.MAX_HOLD(15), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b.slave));

   // Reference model: owner (-1 = none), cycles granted so far, last winner.
   int m_max  [2] = '{4, 15};
   int m_own  [2];
   int m_held [2];
   int m_last [2];
   int m_gid  [2];
   bit m_to   [2];

   task automatic model_step(input int m, input logic [7:0] r, input logic rl, input logic rs);
      int w;
      if (rs) begin
         m_own[m] = -1; m_held[m] = 0; m_last[m] = 7; m_gid[m] = 0; m_to[m] = 0;
         return;
      end
      m_to[m] = 0;
      if (m_own[m] >= 0) begin
         m_held[m]++;
         if (rl || !r[m_own[m]]) m_own[m] = -1;
         else if (m_max[m] != 0 && m_held[m] == m_max[m]) begin
            m_own[m] = -1; m_to[m] = 1;
         end
      end else begin
         w = -1;
         for (int k = 1; k <= 8 && w < 0; k++)
            if (r[(m_last[m] + k) % 8]) w = (m_last[m] + k) % 8;
         if (w >= 0) begin
            m_own[m] = w; m_gid[m] = w; m_last[m] = w; m_held[m] = 0;
         end
      end
   endtask

   // Expected {grant, grant_valid, grant_id, timeout}
   function automatic logic [12:0] mexp(input int m);
      logic [7:0] g;
      g = (m_own[m] >= 0) ? (8'h01 << m_own[m]) : 8'h00;
      return {g, m_own[m] >= 0, 3'(m_gid[m]), m_to[m]};
   endfunction

   function automatic logic [12:0] obs_a();
      return {bus_a.grant_o, bus_a.grant_valid_o, bus_a.grant_id_o, bus_a.timeout_o};
   endfunction
   function automatic logic [12:0] obs_b();
      return {bus_b.grant_o, bus_b.grant_valid_o, bus_b.grant_id_o, bus_b.timeout_o};
   endfunction

   // Drive inputs, clock once, advance models, return at negedge.
   task automatic tick(input logic [7:0] r, input logic rl, input logic rs);
      bus_a.req_i = r; bus_a.release_i = rl;
      bus_b.req_i = r; bus_b.release_i = rl;
      reset = rs;
      @(posedge clk);
      model_step(0, r, rl, rs);
      model_step(1, r, rl, rs);
      @(negedge clk);
   endtask

   task automatic test_reset();
      tick(8'hFF, 1'b0, 1'b1);
      tick(8'hFF, 1'b0, 1'b1);
      n_cmp++;
      if (obs_a() !== 13'h0) begin
         n_fail++; $display("FAIL reset_a got=%h want=%h", obs_a(), 13'h0);
      end
      n_cmp++;
      if (obs_b() !== mexp(1)) begin
         n_fail++; $display("FAIL reset_b got=%h want=%h", obs_b(), mexp(1));
      end
   endtask

   task automatic test_single();
      tick(8'h20, 1'b0, 1'b0);
      n_cmp++;
      if ({bus_a.grant_o, bus_a.grant_valid_o, bus_a.grant_id_o} !== {8'h20, 1'b1, 3'd5}) begin
         n_fail++; $display("FAIL single got=%h/%b/%0d want=20/1/5",
                            bus_a.grant_o, bus_a.grant_valid_o, bus_a.grant_id_o);
      end
   endtask

   task automatic test_rotation();
      logic [7:0] want;
      tick(8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         tick(8'hFF, 1'b1, 1'b0);
         want = 8'h01 << (i % 8);
         n_cmp++;
         if (bus_a.grant_o !== want || obs_a() !== mexp(0)) begin
            n_fail++; $display("FAIL rotation_grant[%0d] got=%h want=%h", i, bus_a.grant_o, want);
         end
         tick(8'hFF, 1'b1, 1'b0);
         n_cmp++;
         if (bus_a.grant_o !== 8'h00 || bus_a.grant_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rotation_gap[%0d] got=%h want=00", i, bus_a.grant_o);
         end
      end
   endtask

   task automatic test_timeout();
      tick(8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick(8'h08, 1'b0, 1'b0);
         n_cmp++;
         if (bus_a.grant_o !== 8'h08 || bus_a.timeout_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_hold[%0d] got=%h/%b want=08/0", i, bus_a.grant_o, bus_a.timeout_o);
         end
      end
      tick(8'h08, 1'b0, 1'b0);
      n_cmp++;
      if (bus_a.grant_o !== 8'h00 || bus_a.timeout_o !== 1'b1) begin
         n_fail++; $display("FAIL timeout_gap got=%h/%b want=00/1", bus_a.grant_o, bus_a.timeout_o);
      end
      tick(8'h08, 1'b0, 1'b0);
      n_cmp++;
      if (bus_a.grant_o !== 8'h08 || bus_a.timeout_o !== 1'b0) begin
         n_fail++; $display("FAIL timeout_regrant got=%h/%b want=08/0", bus_a.grant_o, bus_a.timeout_o);
      end
      // Longer hold exercises the 15-cycle instance too.
      for (int i = 0; i < 20; i++) begin
         tick(8'h08, 1'b0, 1'b0);
         n_cmp++;
         if (obs_b() !== mexp(1)) begin
            n_fail++; $display("FAIL timeout15[%0d] got=%h want=%h", i, obs_b(), mexp(1));
         end
      end
   endtask

   task automatic test_implicit();
      tick(8'h00, 1'b0, 1'b1);
      tick(8'h04, 1'b0, 1'b0);
      tick(8'h40, 1'b0, 1'b0);
      n_cmp++;
      if (bus_a.grant_o !== 8'h00) begin
         n_fail++; $display("FAIL implicit_gap got=%h want=00", bus_a.grant_o);
      end
      tick(8'h40, 1'b0, 1'b0);
      n_cmp++;
      if (bus_a.grant_o !== 8'h40 || bus_a.grant_id_o !== 3'd6) begin
         n_fail++; $display("FAIL implicit_next got=%h want=40", bus_a.grant_o);
      end
   endtask

   task automatic test_wrap();
      tick(8'h00, 1'b0, 1'b1);
      tick(8'h40, 1'b0, 1'b0);
      tick(8'h41, 1'b1, 1'b0);
      tick(8'h41, 1'b0, 1'b0);
      n_cmp++;
      if (bus_a.grant_o !== 8'h01 || bus_a.grant_id_o !== 3'd0) begin
         n_fail++; $display("FAIL wrap got=%h id=%0d want=01 id=0", bus_a.grant_o, bus_a.grant_id_o);
      end
   endtask

   task automatic test_reset_mid();
      tick(8'h00, 1'b0, 1'b1);
      tick(8'h02, 1'b0, 1'b0);
      tick(8'h02, 1'b0, 1'b1);
      n_cmp++;
      if (obs_a() !== 13'h0) begin
         n_fail++; $display("FAIL reset_mid got=%h want=0000", obs_a());
      end
      tick(8'h80, 1'b0, 1'b0);
      n_cmp++;
      if (bus_a.grant_o !== 8'h80 || bus_a.grant_id_o !== 3'd7) begin
         n_fail++; $display("FAIL reset_mid_regrant got=%h want=80", bus_a.grant_o);
      end
   endtask

   task automatic test_random();
      logic [7:0] r;
      logic       rl, rs;
      r = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if (i % 6 == 0) r = 8'($urandom) & 8'($urandom);
         rl = ($urandom_range(0, 4) == 0);
         rs = ($urandom_range(0, 60) == 0);
         tick(r, rl, rs);
         n_cmp++;
         if (obs_a() !== mexp(0)) begin
            n_fail++; $display("FAIL random_a[%0d] got=%h want=%h", i, obs_a(), mexp(0));
         end
         n_cmp++;
         if (obs_b() !== mexp(1)) begin
            n_fail++; $display("FAIL random_b[%0d] got=%h want=%h", i, obs_b(), mexp(1));
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      bus_a.req_i = '0; bus_a.release_i = 1'b0;
      bus_b.req_i = '0; bus_b.release_i = 1'b0;
      test_reset();
      test_single();
      test_rotation();
      test_timeout();
      test_implicit();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
